// File: rtl/whack_pkg.sv
// whack_pkg: state encoding, LFSR constants and delay base shared by whack_round_ctrl.
package whack_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StShow,
    StResult,
    StDone
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,15,13,4 expressed as bit positions 15,14,12,3.
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  localparam int unsigned DELAY_W = 11;
  localparam logic [DELAY_W-1:0] DELAY_BASE_MS = 11'd500;

endpackage

// File: rtl/ms_tick.sv
// ms_tick: prescaler emitting a one-cycle pulse every CLK_PER_MS clocks; i_clr restarts it at 0.
module ms_tick #(
  parameter int unsigned CLK_PER_MS = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_MS - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/whack_round_ctrl.sv
// whack_round_ctrl: whack-a-mole round sequencer with random delay, reaction timing and scoring.
// Optional WHACK_PENALTY_EN: a wrong-mole hit during SHOW counts as a miss and ends the round.
module whack_round_ctrl
  import whack_pkg::*;
#(
  parameter int unsigned NUM_MOLES  = 18,
  parameter int unsigned TIME_W     = 12,
  parameter int unsigned CLK_PER_MS = 50000,
  parameter int unsigned ROUNDS     = 10,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [NUM_MOLES-1:0] hit,
  input  logic [TIME_W-1:0]    timeout_ms,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic [TIME_W-1:0]    react_ms,
  output logic                 react_valid,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic                 busy,
  output logic                 game_over
);

  localparam int unsigned IDX_W = $clog2(NUM_MOLES);
  localparam int unsigned RND_W = $clog2(ROUNDS + 1);

  state_e               r_state, w_state_d;
  logic [15:0]          r_lfsr;
  logic                 r_play_q;
  logic [IDX_W-1:0]     r_idx, r_prev_idx, w_mod, w_sel;
  logic [DELAY_W-1:0]   r_delay_ms, r_delay_tgt;
  logic [TIME_W-1:0]    r_ms, r_timeout;
  logic [RND_W-1:0]     r_round;
  logic [NUM_MOLES-1:0] w_onehot;
  logic                 w_tick, w_clr, w_play_rise, w_start;
  logic                 w_hit_ok, w_penalty, w_score_inc, w_miss_inc;

  ms_tick #(
    .CLK_PER_MS (CLK_PER_MS)
  ) u_ms_tick (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  assign w_clr       = (w_state_d != r_state);
  assign w_play_rise = play && !r_play_q;
  assign w_start     = (r_state == StIdle || r_state == StDone) && w_play_rise;

  // Avoid repeating the previous mole by stepping to the next index.
  assign w_mod = IDX_W'({16'd0, r_lfsr} % NUM_MOLES);
  assign w_sel = (w_mod != r_prev_idx) ? w_mod :
                 (w_mod == IDX_W'(NUM_MOLES - 1)) ? '0 : w_mod + IDX_W'(1);

  assign w_onehot = NUM_MOLES'(1) << r_idx;
  assign w_hit_ok = hit[r_idx];

`ifdef WHACK_PENALTY_EN
  assign w_penalty = |(hit & ~w_onehot);
`else
  assign w_penalty = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_score_inc = 1'b0;
    w_miss_inc  = 1'b0;
    case (r_state)
      StIdle, StDone: if (w_play_rise) w_state_d = StDelay;
      StDelay:        if (r_delay_ms == r_delay_tgt) w_state_d = StShow;
      StShow: begin
        if (w_penalty) begin
          w_miss_inc = 1'b1;
          w_state_d  = StResult;
        end else if (w_hit_ok) begin
          w_score_inc = 1'b1;
          w_state_d   = StResult;
        end else if (r_ms == r_timeout) begin
          w_miss_inc = 1'b1;
          w_state_d  = StResult;
        end
      end
      StResult: w_state_d = (r_round == RND_W'(ROUNDS - 1)) ? StDone : StDelay;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_lfsr        <= LFSR_SEED;
      r_play_q      <= 1'b0;
      r_idx         <= '0;
      r_prev_idx    <= '0;
      r_delay_ms    <= '0;
      r_delay_tgt   <= '0;
      r_ms          <= '0;
      r_timeout     <= '0;
      r_round       <= '0;
      react_ms      <= '0;
      react_valid   <= 1'b0;
      score         <= '0;
      misses        <= '0;
    end else begin
      r_state     <= w_state_d;
      r_lfsr      <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
      r_play_q    <= play;
      react_valid <= 1'b0;

      if (w_state_d == StDelay && r_state != StDelay) begin
        r_delay_tgt <= DELAY_BASE_MS + {1'b0, r_lfsr[9:0]};
        r_delay_ms  <= '0;
      end else if (r_state == StDelay && w_tick) begin
        r_delay_ms <= r_delay_ms + DELAY_W'(1);
      end

      if (r_state == StDelay && w_state_d == StShow) begin
        r_idx      <= w_sel;
        r_prev_idx <= w_sel;
        r_ms       <= '0;
        r_timeout  <= (timeout_ms == '0) ? TIME_W'(1) : timeout_ms;
      end else if (r_state == StShow && w_tick && r_ms != '1) begin
        r_ms <= r_ms + TIME_W'(1);
      end

      if (w_start) begin
        score   <= '0;
        misses  <= '0;
        r_round <= '0;
      end else begin
        if (w_score_inc) begin
          react_ms    <= r_ms;
          react_valid <= 1'b1;
          if (score != '1) score <= score + SCORE_W'(1);
        end
        if (w_miss_inc && misses != '1) misses <= misses + SCORE_W'(1);
        if (r_state == StResult) r_round <= r_round + RND_W'(1);
      end
    end
  end

  assign mole_led  = (r_state == StShow) ? w_onehot : '0;
  assign busy      = (r_state == StDelay) || (r_state == StShow) || (r_state == StResult);
  assign game_over = (r_state == StDone);

endmodule
